mem_access_unit: RTL and testbench

- Load/store initiator that drives the single-port word data memory on behalf of the CPU datapath.
- Accepts one byte, halfword or word load/store request at a time.
- Memory is word-addressed (uses address[6:2]), reads combinationally and writes on posedge when we=1.
- Loads get lane extraction with sign/zero extension; sub-word stores use read-modify-write, since memory only writes whole words.
- Flags misaligned and out-of-range accesses and never touches memory for them.

---
 rtl/mem_access_unit.sv | 168 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for a single-port, word-addressed data memory.
// Byte and halfword loads are lane-extracted and extended. Byte and halfword
// stores use read-modify-write because the memory only accepts whole words.
// Misaligned, illegal-size and out-of-range requests complete with an error
// and never touch memory.
module mem_access_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned LENGTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             resp_valid,
  output logic             resp_err,
  output logic [WIDTH-1:0] resp_rdata,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);

  localparam logic [WIDTH-3:0] LenIdx = (WIDTH-2)'(LENGTH);

  typedef enum logic [2:0] {StIdle, StLoad, StRd, StWr, StResp} state_e;

  state_e state_q, state_d;

  // Request latched at accept
  logic             wr_q;
  logic [1:0]       size_q;
  logic             uns_q;
  logic [WIDTH-1:0] addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             err_q;
  logic [WIDTH-1:0] rdata_q;
  logic [WIDTH-1:0] buf_q;

  logic             req_err;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] merged;
  logic [7:0]       lane_b;
  logic [15:0]      lane_h;

  // Classify the incoming request as erroneous
  always_comb begin
    req_err = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
              (req_addr[WIDTH-1:2] >= LenIdx);
  end

  // Lane extraction for loads and lane merge for sub-word stores
  always_comb begin
    lane_b   = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_h   = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    load_val = mem_rdata;
    merged   = mem_rdata;
    unique case (size_q)
      2'b00: begin
        load_val = uns_q ? {{(WIDTH-8){1'b0}}, lane_b} : {{(WIDTH-8){lane_b[7]}}, lane_b};
        merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
      end
      2'b01: begin
        load_val = uns_q ? {{(WIDTH-16){1'b0}}, lane_h} : {{(WIDTH-16){lane_h[15]}}, lane_h};
        merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      end
      default: begin
        load_val = mem_rdata;
        merged   = mem_rdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (req_err) begin
            state_d = StResp;
          end else if (!req_write) begin
            state_d = StLoad;
          end else if (req_size == 2'b10) begin
            state_d = StWr;
          end else begin
            state_d = StRd;
          end
        end
      end
      StLoad:  state_d = StResp;
      StRd:    state_d = StWr;
      StWr:    state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready  = (state_q == StIdle);
    resp_valid = (state_q == StResp);
    resp_err   = (state_q == StResp) && err_q;
    resp_rdata = (state_q == StResp) ? rdata_q : '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    if ((state_q == StLoad) || (state_q == StRd) || (state_q == StWr)) begin
      mem_addr = {addr_q[WIDTH-1:2], 2'b00};
    end
    if (state_q == StWr) begin
      mem_wdata = (size_q == 2'b10) ? wdata_q : buf_q;
      // No write may reach memory while reset is asserted
      mem_we    = !rst;
    end
  end

  // Request latch, load result and merge buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      buf_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            wr_q    <= req_write;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            err_q   <= req_err;
            rdata_q <= '0;
          end
        end
        StLoad:  rdata_q <= load_val;
        StRd:    buf_q <= merged;
        default: ;
      endcase
    end
  end

  // wr_q is kept for debug visibility of the latched request
  logic unused_wr;
  assign unused_wr = wr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word-level reference memory and
// a per-cycle compare process.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.WIDTH(32), .LENGTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  // Data memory: combinational read, posedge write, plus a preload port
  logic [31:0] mem [32];
  logic        pl_we = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [31:0] pl_dat = '0;
  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[6:2]] <= mem_wdata;
    if (pl_we) mem[pl_idx] <= pl_dat;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory and expected schedule of the current request
  logic [31:0] ref_mem [32];
  int          a_lo = -10, a_hi = -10, m_hi = -10, r_cyc = -10, w_cyc = -10;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0, lit_val = '0;
  logic        e_err = 1'b0, lit_on = 1'b0;
  bit          chk_on = 1'b0, mem_chk = 1'b0, mem_done = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, got, exp);
    end
  endtask

  // Compare process: every cycle, all outputs against the expected schedule
  always @(negedge clk) begin
    if (chk_on) begin
      chk("req_ready", 32'(req_ready), 32'(!(cyc >= a_lo && cyc <= a_hi)));
      chk("resp_valid", 32'(resp_valid), 32'(cyc == r_cyc));
      chk("mem_we", 32'(mem_we), 32'(cyc == w_cyc));
      chk("mem_addr", mem_addr, (cyc >= a_lo && cyc <= m_hi) ? e_addr : 32'h0);
      chk("mem_wdata", mem_wdata, (cyc == w_cyc) ? e_wdata : 32'h0);
      if (cyc == r_cyc) begin
        chk("resp_err", 32'(resp_err), 32'(e_err));
        chk("resp_rdata", resp_rdata, e_rdata);
        if (lit_on) chk("rdata_literal", resp_rdata, lit_val);
      end
      if (rst) begin
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
      end
      if (mem_chk && !mem_done) begin
        mem_done = 1'b1;
        chk("word14", mem[20], 32'h0000_00A3);
        chk("word15", mem[21], 32'hBEEF_5A27);
        chk("word16", mem[22], 32'h1122_3344);
        chk("word18", mem[24], 32'h0000_0258);
        for (int i = 0; i < 32; i++) chk("mem_vs_model", mem[i], ref_mem[i]);
      end
    end
  end

  // Issue one request; expected results come from word-level arithmetic.
  // abort asserts rst during the cycle after accept.
  task automatic issue(input logic w, input logic [1:0] sz, input logic un,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input logic [31:0] lit, input bit abort);
    int          t, lat;
    logic [31:0] idx, word, sh, mask, lane, nw;
    logic        er;
    @(negedge clk);
    #1;
    t    = cyc;
    idx  = ad >> 2;
    er   = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00) ||
           (idx >= 32);
    sh   = (ad & 32'h3) * 8;
    word = er ? 32'h0 : ref_mem[idx[4:0]];
    e_addr  = ad & ~32'h3;
    e_wdata = '0;
    e_rdata = '0;
    e_err   = er;
    w_cyc   = -10;
    if (er) begin
      lat = 1;
    end else if (!w) begin
      lat  = 2;
      lane = word >> sh;
      if (sz == 2'b00) begin
        lane = lane & 32'hFF;
        if (!un && lane[7]) lane = lane | 32'hFFFF_FF00;
      end else if (sz == 2'b01) begin
        lane = lane & 32'hFFFF;
        if (!un && lane[15]) lane = lane | 32'hFFFF_0000;
      end
      e_rdata = lane;
    end else begin
      mask = (sz == 2'b00) ? (32'hFF << sh) : (sz == 2'b01) ? (32'hFFFF << sh) : 32'hFFFF_FFFF;
      nw   = (word & ~mask) | ((wd << sh) & mask);
      e_wdata = nw;
      lat     = (sz == 2'b10) ? 2 : 3;
      w_cyc   = t + lat - 1;
      if (!abort) ref_mem[idx[4:0]] = nw;
    end
    a_lo    = t + 1;
    a_hi    = t + lat;
    m_hi    = t + lat - 1;
    r_cyc   = t + lat;
    lit_val = lit;
    lit_on  = 1'b1;
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = ad;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (abort) begin
      rst   = 1'b1;
      r_cyc = -10;
      w_cyc = -10;
      a_hi  = t + 1;
      m_hi  = t + 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
    end else begin
      repeat (lat) @(posedge clk);
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pl_idx = 5'(i);
      case (i)
        20:      pl_dat = 32'h0000_00A3;
        21:      pl_dat = 32'h0000_0027;
        22:      pl_dat = 32'h1122_3344;
        23:      pl_dat = 32'hDEAD_BEEF;
        default: pl_dat = 32'h0;
      endcase
      ref_mem[i] = pl_dat;
      pl_we = 1'b1;
    end
    @(negedge clk);
    pl_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);

    //     wr    size   uns   addr          wdata         literal       abort
    issue(1'b0, 2'b00, 1'b0, 32'h0000_0050, 32'h0,        32'hFFFF_FFA3, 1'b0);
    issue(1'b0, 2'b00, 1'b1, 32'h0000_0050, 32'h0,        32'h0000_00A3, 1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0055, 32'h0000_005A, 32'h0,        1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0054, 32'h0,        32'h0000_5A27, 1'b0);
    issue(1'b1, 2'b10, 1'b0, 32'h0000_0060, 32'h0000_0258, 32'h0,        1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0062, 32'h0,        32'h0,         1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0052, 32'h0,        32'h0,         1'b0);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0051, 32'h0000_1234, 32'h0,        1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0,        32'h0,         1'b0);
    issue(1'b0, 2'b11, 1'b0, 32'h0000_0040, 32'h0,        32'h0,         1'b0);
    issue(1'b1, 2'b00, 1'b0, 32'h0000_0059, 32'h0000_00CC, 32'h0,        1'b1);
    issue(1'b1, 2'b01, 1'b0, 32'h0000_0056, 32'h0000_BEEF, 32'h0,        1'b0);
    issue(1'b0, 2'b01, 1'b0, 32'h0000_0056, 32'h0,        32'hFFFF_BEEF, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_005B, 32'h0,        32'h0000_0011, 1'b0);
    issue(1'b0, 2'b01, 1'b1, 32'h0000_005A, 32'h0,        32'h0000_1122, 1'b0);
    issue(1'b0, 2'b00, 1'b0, 32'h0000_005C, 32'h0,        32'hFFFF_FFEF, 1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_007C, 32'h0,        32'h0,         1'b0);
    issue(1'b0, 2'b10, 1'b0, 32'h0000_0058, 32'h0,        32'h1122_3344, 1'b0);

    @(negedge clk);
    mem_chk = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
